// File: rtl/keypad_entry_controller.sv
// Turns scanner key events into multi-digit BCD entries and hands completed entries to a consumer.
// Latency: 1 clock from the key edge to entry/value/error. Backpressure: value held until value_ack; Enter while busy is rejected.
// The live entry stays editable while a committed value waits, so the two buffers are independent.
module keypad_entry_controller #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  interrupt,
    input  logic [3:0]            keypad_data,
    input  logic                  value_ack,
    output logic [4*DIGITS-1:0]   entry,
    output logic [2:0]            digit_count,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  error
);

    localparam int W = 4 * DIGITS;
    localparam logic [2:0] MAX_CNT = 3'(DIGITS);

    typedef enum logic {ENTRY, HOLD} state_t;

    state_t         state, state_n;
    logic           int_q;
    logic [W-1:0]   entry_n, value_n;
    logic [2:0]     count_n;
    logic           error_n;
    logic           key_event, is_enter;

    assign key_event   = interrupt & ~int_q;
    assign is_enter    = key_event && (keypad_data == 4'hA);
    assign value_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            // int_q starts high so a key held through reset is not seen as a new press
            int_q       <= 1'b1;
            state       <= ENTRY;
            entry       <= '0;
            digit_count <= '0;
            value       <= '0;
            error       <= 1'b0;
        end else begin
            int_q       <= interrupt;
            state       <= state_n;
            entry       <= entry_n;
            digit_count <= count_n;
            value       <= value_n;
            error       <= error_n;
        end
    end

    always_comb begin
        state_n = state;
        entry_n = entry;
        count_n = digit_count;
        value_n = value;
        error_n = 1'b0;

        if ((state == HOLD) && value_ack && !is_enter)
            state_n = ENTRY;

        if (key_event) begin
            if (keypad_data <= 4'd9) begin
                if (digit_count < MAX_CNT) begin
                    entry_n = (entry << 4) | W'(keypad_data);
                    count_n = digit_count + 3'd1;
                end else begin
                    error_n = 1'b1;
                end
            end else if (keypad_data == 4'hB) begin
                if (digit_count != 3'd0) begin
                    entry_n = entry >> 4;
                    count_n = digit_count - 3'd1;
                end else begin
                    error_n = 1'b1;
                end
            end else if (keypad_data == 4'hC) begin
                entry_n = '0;
                count_n = '0;
            end else if (keypad_data == 4'hA) begin
                // Commit is allowed from ENTRY, or from HOLD when the ack frees the output on this same edge
                if ((state == ENTRY) || value_ack) begin
                    if (digit_count != 3'd0) begin
                        value_n = entry;
                        entry_n = '0;
                        count_n = '0;
                        state_n = HOLD;
                    end else begin
                        state_n = ENTRY;
                        error_n = 1'b1;
                    end
                end else begin
                    error_n = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed and randomized checks of keypad_entry_controller against a digit-queue reference model.
module tb_keypad_entry_controller;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           interrupt = 1'b0;
    logic [3:0]     keypad_data = 4'h0;
    logic           value_ack = 1'b0;
    logic [W-1:0]   entry, value;
    logic [2:0]     digit_count;
    logic           value_valid, error;

    int tests = 0;
    int fails = 0;

    keypad_entry_controller #(.DIGITS(D)) dut (
        .clk(clk), .reset(reset), .interrupt(interrupt), .keypad_data(keypad_data),
        .value_ack(value_ack), .entry(entry), .digit_count(digit_count),
        .value(value), .value_valid(value_valid), .error(error)
    );

    always #5 clk = ~clk;

    // Reference model: the entry is a list of typed digits, oldest first.
    int           m_q[$];
    logic [W-1:0] m_val = '0;
    logic         m_vv  = 1'b0;
    logic         m_err = 1'b0;

    wire [2*W+4:0] obs = {entry, digit_count, value, value_valid, error};

    function automatic logic [W-1:0] m_entry();
        logic [W-1:0] e = '0;
        foreach (m_q[i]) e = (e << 4) | W'(m_q[i]);
        return e;
    endfunction

    function automatic logic [2*W+4:0] exp_vec();
        return {m_entry(), 3'(m_q.size()), m_val, m_vv, m_err};
    endfunction

    task automatic model_commit();
        m_val = m_entry();
        m_q.delete();
        m_vv = 1'b1;
    endtask

    task automatic model_key(input int k, input bit ack);
        m_err = 1'b0;
        if (m_vv && ack && k != 10) m_vv = 1'b0;
        if (k <= 9) begin
            if (m_q.size() < D) m_q.push_back(k);
            else m_err = 1'b1;
        end else if (k == 11) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_err = 1'b1;
        end else if (k == 12) begin
            m_q.delete();
        end else if (k == 10) begin
            if (!m_vv || ack) begin
                if (m_q.size() > 0) model_commit();
                else begin m_vv = 1'b0; m_err = 1'b1; end
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_val = '0;
        m_vv  = 1'b0;
        m_err = 1'b0;
    endtask

    // Press: returns at the negedge after the sampling edge, outputs reflect the key.
    task automatic press(input int k, input bit ack);
        @(negedge clk);
        interrupt   = 1'b1;
        keypad_data = 4'(k);
        value_ack   = ack;
        @(negedge clk);
        model_key(k, ack);
    endtask

    task automatic release_key();
        interrupt = 1'b0;
        value_ack = 1'b0;
        @(negedge clk);
        m_err = 1'b0;
    endtask

    task automatic ack_only();
        interrupt = 1'b0;
        value_ack = 1'b1;
        @(negedge clk);
        m_vv  = 1'b0;
        m_err = 1'b0;
        value_ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; interrupt = 1'b1; keypad_data = 4'h5;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        tests++;
        if (obs !== exp_vec()) begin
            fails++; $display("FAIL reset_held_key: got %h expected %h", obs, exp_vec());
        end
        release_key();
        press(5, 0);
        tests++;
        if (entry !== 16'h0005 || digit_count !== 3'd1) begin
            fails++; $display("FAIL press_after_reset: got %h/%0d expected 0005/1", entry, digit_count);
        end
        release_key();
    endtask

    task automatic test_overflow();
        press(12, 0); release_key();
        for (int d = 1; d <= 4; d++) begin press(d, 0); release_key(); end
        tests++;
        if (entry !== 16'h1234 || digit_count !== 3'd4 || error !== 1'b0) begin
            fails++; $display("FAIL fill_four: got %h/%0d err %b expected 1234/4 err 0", entry, digit_count, error);
        end
        press(5, 0);
        tests++;
        if (obs !== exp_vec() || error !== 1'b1 || entry !== 16'h1234) begin
            fails++; $display("FAIL overflow_error: got %h expected %h", obs, exp_vec());
        end
        release_key();
        tests++;
        if (error !== 1'b0) begin
            fails++; $display("FAIL error_one_cycle: got %b expected 0", error);
        end
    endtask

    task automatic test_backspace();
        press(12, 0); release_key();
        press(7, 0); release_key();
        press(8, 0); release_key();
        tests++;
        if (entry !== 16'h0078) begin
            fails++; $display("FAIL bksp_start: got %h expected 0078", entry);
        end
        press(11, 0); release_key();
        tests++;
        if (entry !== 16'h0007 || digit_count !== 3'd1) begin
            fails++; $display("FAIL bksp_one: got %h/%0d expected 0007/1", entry, digit_count);
        end
        press(11, 0); release_key();
        press(11, 0);
        tests++;
        if (obs !== exp_vec() || error !== 1'b1 || digit_count !== 3'd0) begin
            fails++; $display("FAIL bksp_empty: got %h expected %h", obs, exp_vec());
        end
        release_key();
    endtask

    task automatic test_commit();
        press(4, 0); release_key();
        press(2, 0); release_key();
        press(10, 0);
        tests++;
        if (value !== 16'h0042 || value_valid !== 1'b1 || entry !== 16'h0 || obs !== exp_vec()) begin
            fails++; $display("FAIL commit: got %h expected %h", obs, exp_vec());
        end
        release_key();
        press(9, 0); release_key();
        press(10, 0);
        tests++;
        if (error !== 1'b1 || value !== 16'h0042 || entry !== 16'h0009 || obs !== exp_vec()) begin
            fails++; $display("FAIL enter_busy: got %h expected %h", obs, exp_vec());
        end
        release_key();
        ack_only();
        tests++;
        if (value_valid !== 1'b0 || value !== 16'h0042 || obs !== exp_vec()) begin
            fails++; $display("FAIL ack_drop: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        press(12, 0); release_key();
        press(1, 0); release_key();
        press(10, 0); release_key();
        press(9, 0); release_key();
        press(10, 1);
        tests++;
        if (value !== 16'h0009 || value_valid !== 1'b1 || entry !== 16'h0 ||
            digit_count !== 3'd0 || error !== 1'b0 || obs !== exp_vec()) begin
            fails++; $display("FAIL enter_with_ack: got %h expected %h", obs, exp_vec());
        end
        release_key();
    endtask

    task automatic test_empty_and_reset();
        ack_only();
        press(10, 0);
        tests++;
        if (error !== 1'b1 || value_valid !== 1'b0 || obs !== exp_vec()) begin
            fails++; $display("FAIL empty_enter: got %h expected %h", obs, exp_vec());
        end
        release_key();
        press(14, 0);
        tests++;
        if (error !== 1'b0 || obs !== exp_vec()) begin
            fails++; $display("FAIL ignored_key: got %h expected %h", obs, exp_vec());
        end
        release_key();
        press(3, 0); release_key();
        press(10, 0); release_key();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tests++;
        if (obs !== {(2*W+5){1'b0}} || obs !== exp_vec()) begin
            fails++; $display("FAIL reset_in_hold: got %h expected 0", obs);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int sel = $urandom_range(0, 9);
            int k;
            bit a = ($urandom_range(0, 2) == 0);
            if (sel <= 4)      k = $urandom_range(0, 9);
            else if (sel == 5) k = 10;
            else if (sel == 6) k = 11;
            else if (sel == 7) k = 12;
            else               k = $urandom_range(13, 15);
            if (sel == 9) begin
                ack_only();
            end else begin
                press(k, a);
                tests++;
                if (obs !== exp_vec()) begin
                    fails++; $display("FAIL random_key %0d (code %0d ack %0d): got %h expected %h", n, k, a, obs, exp_vec());
                end
                release_key();
            end
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL random_idle %0d: got %h expected %h", n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_backspace();
        test_commit();
        test_back_to_back();
        test_empty_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_entry_controller.md
# keypad_entry_controller

Sequences raw key events from the `keypad_controller` scanner into multi-digit numeric entries for the rest of the design. Edge-detects `interrupt` and decodes `keypad_data` as digits 0–9 or the commands Enter, Backspace and Clear. Accumulates up to DIGITS BCD digits and presents a completed entry to a downstream consumer over a valid/ack handshake. Sits directly between the keypad scanner and the consumer (display/CPU logic).

## Interface

- DIGITS, 4, maximum digits per entry; legal range 1–7.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- interrupt  input  1  key-present level from the scanner; high while a key is held.
- keypad_data  input  4  key code from the scanner; valid whenever interrupt is high.
- value_ack  input  1  consumer accepts `value`; sampled only while value_valid=1.
- entry  output  4*DIGITS  live entry buffer, BCD, most recent digit in bits [3:0].
- digit_count  output  3  number of digits currently in `entry` (0..DIGITS).
- value  output  4*DIGITS  committed entry, BCD; stable while value_valid=1.
- value_valid  output  1  committed value waiting for ack.
- error  output  1  one-cycle pulse on a rejected key.

## Operation

- Key event: `int_q` registers `interrupt`. Event occurs on an edge where interrupt=1 and int_q=0. `keypad_data` is sampled on that same edge. Holding a key yields exactly one event.
- Key decode:
  - 0x0–0x9 = digit.
  - 0xA = Enter.
  - 0xB = Backspace.
  - 0xC = Clear.
  - 0xD–0xF are ignored: no state change, no error.
- Digit:
  - If digit_count<DIGITS: entry <= {entry[4*DIGITS-5:0], digit} and digit_count+1.
  - Otherwise error=1 and entry is unchanged.
- Backspace:
  - If digit_count>0: entry <= entry>>4, zero-filling the top nibble, and digit_count-1.
  - Otherwise error=1.
- Clear: entry <= 0 and digit_count <= 0. Never an error.
- Enter: behaviour depends on state (see the state machine below).
- State machine has two states, ENTRY and HOLD.
  - ENTRY, Enter with digit_count>0: value <= entry, value_valid <= 1, entry <= 0, digit_count <= 0, go to HOLD.
  - ENTRY, Enter with digit_count=0: error=1, stay in ENTRY.
  - HOLD: value_valid=1 and `value` is frozen. Digit, Backspace and Clear keep editing `entry` normally (double-buffered).
  - HOLD, value_ack=1 with no Enter event on that edge: value_valid <= 0, go to ENTRY.
  - HOLD, Enter event with value_ack=0: error=1. value, entry and digit_count are unchanged (busy).
  - HOLD, Enter event and value_ack=1 on the same edge: if digit_count>0, value <= entry, entry and digit_count clear, value_valid stays 1, stay in HOLD. If digit_count=0, the ack is honoured (value_valid <= 0, go to ENTRY) and error=1.
- value_ack while in ENTRY is ignored.
- `value` holds its last committed contents after ack. It changes only on a commit.

## Timing

- Reset values:
  - entry=0, digit_count=0, value=0, value_valid=0, error=0, state=ENTRY.
  - int_q=1, so a key held through reset produces no event until it is released and pressed again.
- Reset takes priority over every other input on the same edge. Reset during HOLD drops value_valid on that edge.
- Latency: a key event sampled on edge k is reflected in entry, digit_count, value, value_valid and error immediately after edge k (1 clock).
- error is high for exactly the one cycle following the offending edge.
- value_valid falls on the edge where ack is sampled. Minimum HOLD residency is 1 cycle.
- Back-to-back events are impossible: an event needs interrupt low for at least one sampled cycle between presses.

## Test plan

- Reset with interrupt=1, keypad_data=0x5 held -> no event, entry=0, digit_count=0; release then press 0x5 -> entry=0x0005, digit_count=1 one clock later.
- Press 1, 2, 3, 4, then 5 (DIGITS=4) -> entry=0x1234, digit_count=4, one-cycle error pulse on the fifth key, entry unchanged.
- Press 7, 8, Backspace, Backspace, Backspace -> entry 0x0078, then 0x0007, then 0x0000; error on the third Backspace; digit_count ends at 0.
- Press 4, 2, Enter -> value=0x0042, value_valid=1, entry=0; press 9 and Enter with no ack -> error pulse, value stays 0x0042, entry=0x0009; assert value_ack -> value_valid=0 next cycle.
- In HOLD with entry=0x0009, Enter edge coincident with value_ack=1 -> value=0x0009, value_valid stays 1, entry=0, digit_count=0, no error.
- Enter with digit_count=0 -> error pulse, value_valid stays 0; press 0xE -> no change, no error; assert reset mid-HOLD -> all outputs at reset values after that edge.
